// File: rtl/fpu_sgnj_issue_pkg.sv
// Shared constants and types for the FSGNJ issue stage and its skid FIFO.
// Optional NaN-boxing of BF16 operands is enabled by FPU_SGNJ_NANBOX_EN.
package fpu_sgnj_pkg;

  localparam logic [2:0] F3_SGNJ  = 3'b000;
  localparam logic [2:0] F3_SGNJN = 3'b001;
  localparam logic [2:0] F3_SGNJX = 3'b010;

  localparam logic [2:0] OP_SGNJ  = 3'b001;
  localparam logic [2:0] OP_SGNJN = 3'b010;
  localparam logic [2:0] OP_SGNJX = 3'b100;

  localparam logic [15:0] CANON_NAN_BF16 = 16'h7FC0;
  localparam logic [31:0] CANON_NAN_FP32 = 32'h7FC0_0000;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  // Unsupported funct3 maps to an all-zero op, which marks it illegal.
  function automatic logic [2:0] decode_f3(input logic [2:0] f3);
    case (f3)
      F3_SGNJ:  decode_f3 = OP_SGNJ;
      F3_SGNJN: decode_f3 = OP_SGNJN;
      F3_SGNJX: decode_f3 = OP_SGNJX;
      default:  decode_f3 = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/fpu_sgnj_issue_if.sv
// Request/response bundle between FPU dispatch, the issue stage and the
// sign-injection unit. InW is 32 when FPU_SGNJ_NANBOX_EN is compiled in.
interface fpu_sgnj_issue_if #(
  parameter int Std  = 31,
  parameter int TagW = 5,
  parameter int InW  = Std + 1
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [InW-1:0]  in_rs1;
  logic [InW-1:0]  in_rs2;
  logic [TagW-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      op;
  logic [Std:0]    IEEE_A;
  logic [Std:0]    IEEE_B;
  logic [TagW-1:0] out_rd;
  logic            out_illegal;
  logic [15:0]     issue_cnt;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, op, IEEE_A, IEEE_B, out_rd, out_illegal, issue_cnt
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, op, IEEE_A, IEEE_B, out_rd, out_illegal, issue_cnt
  );
endinterface

// File: rtl/fpu_sgnj_issue_fifo2.sv
// Generic 2-entry skid FIFO; occupancy is held as a small FSM so ready/valid
// come straight from registered state.
module fpu_sgnj_fifo2
  import fpu_sgnj_pkg::*;
#(
  parameter int W     = 8,
  parameter int Depth = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  fifo_state_e  state_q, state_d;
  logic         wptr_q, rptr_q;
  logic [W-1:0] mem_q [2];
  logic         push, pop;

  assign push = push_valid & push_ready;
  assign pop  = pop_valid & pop_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FIFO_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FIFO_EMPTY: if (push) state_d = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_d = FIFO_FULL;
        else if (pop && !push) state_d = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop) state_d = FIFO_ONE;
      default:    state_d = FIFO_EMPTY;
    endcase
  end

  // Ready/valid are held low during the reset cycle itself.
  always_comb begin
    push_ready = ~rst & (int'(state_q) < Depth);
    pop_valid  = ~rst & (state_q != FIFO_EMPTY);
    pop_data   = mem_q[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

endmodule

// File: rtl/fpu_sgnj_issue.sv
// FSGNJ issue stage: decodes funct3 to a one-hot op, buffers in a skid FIFO.
// FPU_SGNJ_NANBOX_EN: 32-bit inputs, non-boxed BF16 operands become 0x7FC0.
module fpu_sgnj_issue
  import fpu_sgnj_pkg::*;
#(
  parameter int Std   = 31,
  parameter int TagW  = 5,
  parameter int Depth = 2
) (
  input  logic clk,
  input  logic rst_l,
  fpu_sgnj_issue_if.slave bus
);

  typedef struct packed {
    logic [2:0]      op;
    logic            illegal;
    logic [Std:0]    a;
    logic [Std:0]    b;
    logic [TagW-1:0] rd;
  } entry_t;

`ifdef FPU_SGNJ_NANBOX_EN
  localparam logic [Std:0] NAN_C = (Std == 15) ? (Std+1)'(CANON_NAN_BF16)
                                               : (Std+1)'(CANON_NAN_FP32);
`endif

  entry_t      wr_e, rd_e;
  logic        head_vld;
  logic        push_ok;
  logic [15:0] issue_cnt_q;

  always_comb begin
    wr_e         = '0;
    wr_e.op      = decode_f3(bus.in_funct3);
    wr_e.illegal = (wr_e.op == 3'b000);
    wr_e.rd      = bus.in_rd;
`ifdef FPU_SGNJ_NANBOX_EN
    wr_e.a = (bus.in_rs1[31:16] == 16'hFFFF) ? bus.in_rs1[Std:0] : NAN_C;
    wr_e.b = (bus.in_rs2[31:16] == 16'hFFFF) ? bus.in_rs2[Std:0] : NAN_C;
`else
    wr_e.a = bus.in_rs1;
    wr_e.b = bus.in_rs2;
`endif
  end

  fpu_sgnj_fifo2 #(.W($bits(entry_t)), .Depth(Depth)) u_fifo (
    .clk        (clk),
    .rst        (rst_l),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (wr_e),
    .pop_valid  (head_vld),
    .pop_ready  (bus.out_ready),
    .pop_data   (rd_e)
  );

  assign push_ok = bus.in_valid & bus.in_ready;

  // Illegal entries occupy a slot but are not counted as issues.
  always_ff @(posedge clk) begin
    if (rst_l)                         issue_cnt_q <= '0;
    else if (push_ok && !wr_e.illegal) issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign bus.issue_cnt = issue_cnt_q;
  assign bus.out_valid = head_vld;

  always_comb begin
    bus.op          = 3'b000;
    bus.IEEE_A      = '0;
    bus.IEEE_B      = '0;
    bus.out_rd      = '0;
    bus.out_illegal = 1'b0;
    if (head_vld) begin
      bus.op          = rd_e.op;
      bus.IEEE_A      = rd_e.a;
      bus.IEEE_B      = rd_e.b;
      bus.out_rd      = rd_e.rd;
      bus.out_illegal = rd_e.illegal;
    end
  end

endmodule

// File: tb/tb_fpu_sgnj_issue.sv
// Scoreboard bench for fpu_sgnj_issue: driver pushes expected entries on
// accept, a separate monitor compares the head whenever out_valid is high.
module tb_fpu_sgnj_issue;

`ifdef FPU_SGNJ_NANBOX_EN
  localparam int Std = 15;
  localparam logic [31:0] BOX = 32'hFFFF_0000;
`else
  localparam int Std = 31;
  localparam logic [31:0] BOX = 32'h0;
`endif
  localparam int TagW = 5;
  localparam int InW  = 32;

  typedef struct {
    logic [2:0]      op;
    logic            ill;
    logic [Std:0]    a;
    logic [Std:0]    b;
    logic [TagW-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  always #5 clk = ~clk;

  fpu_sgnj_issue_if #(.Std(Std), .TagW(TagW), .InW(InW)) bus ();

  fpu_sgnj_issue #(.Std(Std), .TagW(TagW), .Depth(2)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] cnt_model = 16'd0;
  logic [15:0] cnt_seen = 16'd0;
  bit          pushed_now = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [Std:0] unbox(input logic [InW-1:0] v);
`ifdef FPU_SGNJ_NANBOX_EN
    logic [15:0] hi;
    hi = v[31:16];
    return (hi == 16'hFFFF) ? v[15:0] : 16'h7FC0;
`else
    return v;
`endif
  endfunction

  function automatic exp_t model(input logic [2:0] f3, input logic [InW-1:0] r1,
                                 input logic [InW-1:0] r2, input logic [TagW-1:0] rd);
    exp_t e;
    e.ill = 1'b0;
    case (f3)
      3'd0:    e.op = 3'b001;
      3'd1:    e.op = 3'b010;
      3'd2:    e.op = 3'b100;
      default: begin e.op = 3'b000; e.ill = 1'b1; end
    endcase
    e.a  = unbox(r1);
    e.b  = unbox(r2);
    e.rd = rd;
    return e;
  endfunction

  // Inputs change at negedge; acceptance is judged 1 time unit later.
  task automatic drive(input bit rst, input bit v, input logic [2:0] f3,
                       input logic [InW-1:0] r1, input logic [InW-1:0] r2,
                       input logic [TagW-1:0] rd, input bit ordy, output bit acc);
    @(negedge clk);
    rst_l         = rst;
    bus.in_valid  = v;
    bus.in_funct3 = f3;
    bus.in_rs1    = r1;
    bus.in_rs2    = r2;
    bus.in_rd     = rd;
    bus.out_ready = ordy;
    #1;
    acc        = 1'b0;
    pushed_now = 1'b0;
    cnt_seen   = cnt_model;
    if (rst) begin
      q.delete();
      cnt_model = 16'd0;
      cnt_seen  = 16'd0;
    end else if (v && bus.in_ready) begin
      acc = 1'b1;
      q.push_back(model(f3, r1, r2, rd));
      pushed_now = 1'b1;
      if (f3 <= 3'd2) cnt_model = cnt_model + 16'd1;
    end
  endtask

  task automatic idle(input bit ordy);
    bit a;
    drive(1'b0, 1'b0, 3'd0, '0, '0, '0, ordy, a);
  endtask

  // Monitor: compares the DUT head with the oldest expected entry.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (mon_en && rst_l == 1'b0) begin
      check("issue_cnt", 64'(bus.issue_cnt), 64'(cnt_seen));
      if (bus.out_valid) begin
        if (q.size() <= int'(pushed_now)) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=valid required=idle t=%0t", $time);
        end else begin
          e = q[0];
          check("head_op",  64'(bus.op),          64'(e.op));
          check("head_ill", 64'(bus.out_illegal), 64'(e.ill));
          check("head_a",   64'(bus.IEEE_A),      64'(e.a));
          check("head_b",   64'(bus.IEEE_B),      64'(e.b));
          check("head_rd",  64'(bus.out_rd),      64'(e.rd));
          if (bus.out_ready) void'(q.pop_front());
        end
      end else begin
        check("missing_out", 64'(q.size() - int'(pushed_now)), 64'd0);
        check("idle_op", 64'(bus.op), 64'd0);
        check("idle_data", 64'({bus.IEEE_A, bus.IEEE_B}), 64'd0);
        check("idle_rd_ill", 64'({bus.out_rd, bus.out_illegal}), 64'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, a1, a2, a3, have;
    logic [2:0]      f3;
    logic [InW-1:0]  r1, r2;
    logic [TagW-1:0] rd;

    bus.in_valid = 1'b1; bus.in_funct3 = 3'd0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_rd = '0; bus.out_ready = 1'b0;

    // Reset with a live request on the input.
    drive(1'b1, 1'b1, 3'd0, BOX | 32'h1111, BOX | 32'h2222, 5'd3, 1'b0, acc);
    drive(1'b1, 1'b1, 3'd0, BOX | 32'h1111, BOX | 32'h2222, 5'd3, 1'b0, acc);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_op",        64'(bus.op),        64'd0);
    check("rst_issue_cnt", 64'(bus.issue_cnt), 64'd0);
    idle(1'b1);
    check("ready_after_rst", 64'(bus.in_ready), 64'd1);
    mon_en = 1'b1;

    // Single sgnjn issue.
    drive(1'b0, 1'b1, 3'b001, BOX | 32'h3F80, BOX | 32'h4000, 5'd5, 1'b1, acc);
    check("single_acc", 64'(acc), 64'd1);
    idle(1'b1);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_op",    64'(bus.op),        64'h2);
    check("single_a",     64'(bus.IEEE_A),    64'h3F80);
    check("single_b",     64'(bus.IEEE_B),    64'h4000);
    check("single_rd",    64'(bus.out_rd),    64'd5);
    check("single_cnt",   64'(bus.issue_cnt), 64'd1);
    idle(1'b1);

    // Backpressure: two accepts fill the FIFO, the third must wait.
    drive(1'b0, 1'b1, 3'd0, BOX | 32'hA1, BOX | 32'hB1, 5'd1, 1'b0, a1);
    drive(1'b0, 1'b1, 3'd2, BOX | 32'hA2, BOX | 32'hB2, 5'd2, 1'b0, a2);
    drive(1'b0, 1'b1, 3'd1, BOX | 32'hA3, BOX | 32'hB3, 5'd3, 1'b0, a3);
    check("bp_acc", 64'({a1, a2, a3}), 64'b110);
    check("bp_ready_low", 64'(bus.in_ready), 64'd0);
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++)
      drive(1'b0, 1'b1, 3'd1, BOX | 32'hA3, BOX | 32'hB3, 5'd3, 1'b1, acc);
    check("bp_third_acc", 64'(acc), 64'd1);
    repeat (4) idle(1'b1);

    // Streaming: push+pop every cycle keeps in_ready high.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 3'(i % 3), BOX | 32'(i * 7), BOX | 32'(i * 13), 5'(i), 1'b1, acc);
      check("stream_acc", 64'(acc), 64'd1);
    end
    repeat (2) idle(1'b1);

    // Illegal funct3 occupies a slot but is not counted.
    drive(1'b0, 1'b1, 3'b011, BOX | 32'h55, BOX | 32'h66, 5'd9, 1'b1, acc);
    idle(1'b1);
    check("ill_valid", 64'(bus.out_valid),   64'd1);
    check("ill_op",    64'(bus.op),          64'd0);
    check("ill_flag",  64'(bus.out_illegal), 64'd1);
    check("ill_cnt",   64'(bus.issue_cnt),   64'(cnt_model));
    idle(1'b1);

`ifdef FPU_SGNJ_NANBOX_EN
    drive(1'b0, 1'b1, 3'd0, 32'h0000_3F80, 32'hFFFF_4000, 5'd4, 1'b1, acc);
    idle(1'b1);
    check("nanbox_bad_a",  64'(bus.IEEE_A), 64'h7FC0);
    check("nanbox_good_b", 64'(bus.IEEE_B), 64'h4000);
    drive(1'b0, 1'b1, 3'd0, 32'hFFFF_3F80, 32'h1234_4000, 5'd4, 1'b1, acc);
    idle(1'b1);
    check("nanbox_good_a", 64'(bus.IEEE_A), 64'h3F80);
    check("nanbox_bad_b",  64'(bus.IEEE_B), 64'h7FC0);
    idle(1'b1);
`endif

    // Random traffic; the requester holds a request until accepted.
    have = 1'b0; f3 = '0; r1 = '0; r2 = '0; rd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        f3   = 3'($urandom_range(0, 7));
`ifdef FPU_SGNJ_NANBOX_EN
        r1 = {($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF, 16'($urandom)};
        r2 = {($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF, 16'($urandom)};
`else
        r1 = $urandom;
        r2 = $urandom;
`endif
        rd = 5'($urandom);
      end
      drive(c == 200, have, f3, r1, r2, rd, $urandom_range(0, 2) != 0, acc);
      if (acc || c == 200) have = 1'b0;
    end

    repeat (6) idle(1'b1);
    check("drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_sgnj_issue.md
Name: fpu_sgnj_issue

Overview:
Issue/decode stage directly upstream of the FPU sign-injection unit. Accepts FSGNJ-class requests from the FPU dispatch path over a valid/ready handshake and decodes funct3 into the unit's one-hot op vector (bit0 sgnj, bit1 sgnjn, bit2 sgnjx). Buffers operands and the destination tag in a 2-entry skid FIFO, then presents registered IEEE_A/IEEE_B/op to the sign-injection unit. Unsupported funct3 values are flagged and never reach the unit as a live operation.

Parameters:
Std, 31, operand MSB index (width-1)
TagW, 5, destination register tag width
Depth, 2, FIFO entries; fixed at 2, other values unsupported

Ports:
clk  in  1  clock
rst_l  in  1  synchronous reset, active-high; name kept for codebase consistency
in_valid  in  1  request valid
in_ready  out  1  stage can accept; equals (count < 2), driven from registered count
in_funct3  in  3  000 sgnj, 001 sgnjn, 010 sgnjx, others illegal
in_rs1  in  Std+1  operand A (magnitude and sign source)
in_rs2  in  Std+1  operand B (sign source)
in_rd  in  TagW  destination tag
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head
op  out  3  one-hot op to sign-injection unit; 000 when not valid or illegal
IEEE_A  out  Std+1  head operand A
IEEE_B  out  Std+1  head operand B
out_rd  out  TagW  head tag
out_illegal  out  1  head entry carried an illegal funct3
issue_cnt  out  16  count of accepted legal requests, wraps at 0xFFFF -> 0

Behaviour:
- Reset, synchronous while rst_l=1: count=0, read/write pointers=0, issue_cnt=0. out_valid=0, op=000, IEEE_A/IEEE_B/out_rd=0, out_illegal=0, in_ready=0 during the reset cycle and 1 on the first cycle after.
- Reset mid-operation discards all buffered entries; nothing is replayed.
- Accept: in_valid & in_ready at a clock edge writes {decoded op, illegal, rs1, rs2, rd} into the entry at wptr. Decode: 000->001, 001->010, 010->100, anything else -> op=000 with illegal=1.
- Latency: an entry accepted at edge N shows out_valid=1 after edge N when the FIFO was empty. No combinational path from in_* to out_*.
- Pop: out_valid & out_ready at the edge advances rptr.
- Outputs are read from the entry at rptr. While out_valid=0, all data outputs are forced to 0 and op=000.
- State by count: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE.
  - FULL: pop -> ONE. A push is impossible because in_ready=0.
- Pointers are 1-bit and wrap 1->0.
- in_valid while in_ready=0: the request is ignored and nothing is captured. The upstream requester must hold its request.
- An illegal entry still occupies a FIFO slot and must be popped by the downstream. It does not increment issue_cnt.
- Once out_valid=1, the head contents stay stable until popped.

Optional Feature:
FPU_SGNJ_NANBOX_EN, for the BF16 configuration only (Std=15 inner operands, 32-bit registers).
- Compiled in: in_rs1/in_rs2 widen to 32 bits. Each operand's upper 16 bits are checked at accept time. Any operand whose upper half is not 0xFFFF is replaced by canonical BF16 NaN 0x7FC0 before storage. The output result is re-boxed downstream.
- Compiled out: operands pass through unchanged at Std+1 bits.

Decomposition:
- Package fpu_sgnj_pkg holds:
  - funct3 localparams: F3_SGNJ=3'b000, F3_SGNJN=3'b001, F3_SGNJX=3'b010.
  - One-hot op localparams: OP_SGNJ=3'b001, OP_SGNJN=3'b010, OP_SGNJX=3'b100.
  - Canonical NaN constants: 0x7FC0 (BF16) and 0x7FC00000 (FP32).
- One natural sub-module: fpu_sgnj_fifo2, a generic 2-entry skid FIFO with count and pointers. The decode logic stays in the top-level block.

Test Plan:
- Reset: hold rst_l=1 for 2 cycles with in_valid=1 -> out_valid=0, op=000, issue_cnt=0, nothing captured. in_ready=1 on the cycle after reset deasserts.
- Single issue: funct3=001, rs1=0x3F80, rs2=0x4000, rd=5, out_ready=1 -> next cycle out_valid=1, op=010, IEEE_A=0x3F80, IEEE_B=0x4000, out_rd=5; issue_cnt=1.
- Backpressure: out_ready=0 with three back-to-back requests -> in_ready drops after 2 accepts, the third is not captured, and the head stays stable. Then out_ready=1 -> entries are popped in order.
- Simultaneous push/pop in ONE state with continuous streaming -> count stays 1 and throughput is one request per cycle.
- Illegal funct3=011 -> out_valid=1, op=000, out_illegal=1, issue_cnt unchanged. The entry is popped normally.
- With FPU_SGNJ_NANBOX_EN: rs1=0x0000_3F80 (not NaN-boxed) -> IEEE_A=0x7FC0. rs1=0xFFFF_3F80 -> IEEE_A=0x3F80.
